// File: rtl/sfilt_seq_if.sv
// Sample, config and filter-command signals of the sfilt tap sequencer.
// master drives samples/config; slave is the sequencer itself.
interface sfilt_seq_if;
    logic        in_push;
    logic [31:0] in_data;
    logic        in_ready;
    logic        cfg_we;
    logic [7:0]  cfg_addr;
    logic [31:0] cfg_data;
    logic        cfg_err;
    logic        f_pushin;
    logic [1:0]  f_cmd;
    logic [31:0] f_q;
    logic [31:0] f_h;
    logic        busy;

    modport master (
        output in_push, in_data, cfg_we, cfg_addr, cfg_data,
        input  in_ready, cfg_err, f_pushin, f_cmd, f_q, f_h, busy
    );
    modport slave (
        input  in_push, in_data, cfg_we, cfg_addr, cfg_data,
        output in_ready, cfg_err, f_pushin, f_cmd, f_q, f_h, busy
    );
endinterface

// File: rtl/sfilt_seq.sv
// Tap sequencer for the sfilt MAC: holds coefficients and a circular sample
// history, and emits first-mult / MAC / shift / send bursts per accepted sample.
module sfilt_seq #(
    parameter int NTAPS = 8,
    parameter int AW    = (NTAPS > 1) ? $clog2(NTAPS) : 1
) (
    input  logic       clk,
    input  logic       rst,
    sfilt_seq_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_MAC, S_SHIFT, S_OUT} state_t;

    localparam logic [AW-1:0] LAST    = AW'(NTAPS - 1);
    localparam logic [AW:0]   NTAPS_W = (AW + 1)'(NTAPS);

    state_t        state_q, state_d;
    logic [AW-1:0] k_q, k_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [6:0]    shift_q, shift_d;
    logic [31:0]   coef_q [NTAPS];
    logic [31:0]   coef_d [NTAPS];
    logic [31:0]   hist_q [NTAPS];
    logic [31:0]   hist_d [NTAPS];
    logic          f_pushin_q, f_pushin_d;
    logic [1:0]    f_cmd_q, f_cmd_d;
    logic [31:0]   f_q_q, f_q_d;
    logic [31:0]   f_h_q, f_h_d;
    logic          cfg_err_q, cfg_err_d;

    logic accept;
    logic cfg_ok;

    // (w - k) mod NTAPS without requiring NTAPS to be a power of two
    function automatic logic [AW-1:0] hist_idx(input logic [AW-1:0] w, input logic [AW-1:0] k);
        logic [AW:0] wrapped;
        wrapped = {1'b0, w} + NTAPS_W - {1'b0, k};
        if (w >= k) begin
            return w - k;
        end
        return wrapped[AW-1:0];
    endfunction

    assign accept = (state_q == S_IDLE) && bus.in_push;
    assign cfg_ok = (state_q == S_IDLE) && !bus.in_push && bus.cfg_we;

    always_comb begin
        for (int i = 0; i < NTAPS; i++) begin
            coef_d[i] = coef_q[i];
            hist_d[i] = hist_q[i];
        end
        shift_d   = shift_q;
        cfg_err_d = bus.cfg_we && ((state_q != S_IDLE) || bus.in_push);
        if (cfg_ok && (bus.cfg_addr < 8'(NTAPS))) begin
            coef_d[bus.cfg_addr[AW-1:0]] = bus.cfg_data;
        end
        if (cfg_ok && (bus.cfg_addr == 8'hFF)) begin
            shift_d = bus.cfg_data[6:0];
        end
        if (accept) begin
            hist_d[wptr_q] = bus.in_data;
        end
    end

    // Outputs are registered one step ahead: each branch prepares what the
    // next state presents, so tap 0 takes the incoming sample directly.
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        wptr_d     = wptr_q;
        f_pushin_d = 1'b0;
        f_cmd_d    = 2'd0;
        f_q_d      = '0;
        f_h_d      = '0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.in_push) begin
                    state_d    = S_MAC;
                    k_d        = '0;
                    f_pushin_d = 1'b1;
                    f_cmd_d    = 2'd0;
                    f_q_d      = bus.in_data;
                    f_h_d      = coef_q[0];
                end
            end
            S_MAC: begin
                f_pushin_d = 1'b1;
                if (k_q == LAST) begin
                    state_d = S_SHIFT;
                    f_cmd_d = 2'd2;
                    f_h_d   = {25'b0, shift_q};
                end else begin
                    k_d     = k_q + 1'b1;
                    f_cmd_d = 2'd1;
                    f_q_d   = hist_q[hist_idx(wptr_q, k_d)];
                    f_h_d   = coef_q[k_d];
                end
            end
            S_SHIFT: begin
                state_d    = S_OUT;
                f_pushin_d = 1'b1;
                f_cmd_d    = 2'd3;
            end
            S_OUT: begin
                state_d = S_IDLE;
                wptr_d  = (wptr_q == LAST) ? '0 : wptr_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            k_q        <= '0;
            wptr_q     <= '0;
            shift_q    <= '0;
            f_pushin_q <= 1'b0;
            f_cmd_q    <= 2'd0;
            f_q_q      <= '0;
            f_h_q      <= '0;
            cfg_err_q  <= 1'b0;
            for (int i = 0; i < NTAPS; i++) begin
                coef_q[i] <= '0;
                hist_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            wptr_q     <= wptr_d;
            shift_q    <= shift_d;
            f_pushin_q <= f_pushin_d;
            f_cmd_q    <= f_cmd_d;
            f_q_q      <= f_q_d;
            f_h_q      <= f_h_d;
            cfg_err_q  <= cfg_err_d;
            for (int i = 0; i < NTAPS; i++) begin
                coef_q[i] <= coef_d[i];
                hist_q[i] <= hist_d[i];
            end
        end
    end

    assign bus.in_ready = (state_q == S_IDLE) && !rst;
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.f_pushin = f_pushin_q;
    assign bus.f_cmd    = f_cmd_q;
    assign bus.f_q      = f_q_q;
    assign bus.f_h      = f_h_q;
    assign bus.cfg_err  = cfg_err_q;
endmodule

// File: tb/tb_sfilt_seq.sv
// Bench for sfilt_seq: an FIR reference predicts every burst, and a small
// sfilt model turns the observed commands into z for comparison.
module tb_sfilt_seq;
    localparam int N  = 8;
    localparam int BL = N + 2;

    typedef struct packed {
        logic [BL-1:0][31:0] q;
        logic [BL-1:0][31:0] h;
        logic [31:0]         y;
    } burst_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    sfilt_seq_if bus();
    sfilt_seq #(.NTAPS(N)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int rst_edges = 0;
    int cfg_err_cnt = 0;
    int pos = -1;
    burst_t exp_bq[$];
    burst_t cur;
    int accept_cyc[$];
    longint acc = 0;
    longint rnd = 0;
    int qi, hi, sh;
    logic [31:0] z;

    int coef_m [N];
    int shift_m = 0;
    int samples[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int rnd16();
        return int'($urandom_range(65535, 0)) - 32768;
    endfunction

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        rst_edges <= rst ? rst_edges + 1 : 0;
    end

    // Burst monitor: samples mid-cycle, checks every command and the final z
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_in_ready", bus.in_ready, 0);
            if (rst_edges > 0) chk("rst_pushin", bus.f_pushin, 0);
            exp_bq.delete();
            pos = -1;
        end else begin
            if (bus.cfg_err) cfg_err_cnt++;
            chk("pushin", bus.f_pushin, pos >= 0);
            if (pos >= 0) begin
                if (pos == 0) begin
                    if (exp_bq.size() == 0) chk("burst_expected", 0, 1);
                    else cur = exp_bq.pop_front();
                end
                chk("cmd", bus.f_cmd, (pos == 0) ? 0 : (pos < N) ? 1 : (pos == N) ? 2 : 3);
                chk("q", bus.f_q, cur.q[pos]);
                chk("h", bus.f_h, cur.h[pos]);
                qi = bus.f_q;
                hi = bus.f_h;
                case (bus.f_cmd)
                    2'd0: acc = longint'(qi) * longint'(hi);
                    2'd1: acc = acc + longint'(qi) * longint'(hi);
                    2'd2: begin
                        sh  = int'(bus.f_h[6:0]);
                        rnd = acc >>> sh;
                        if (sh > 0) rnd = rnd + longint'(acc[sh-1]);
                    end
                    default: ;
                endcase
                if (pos == N + 1) begin
                    z = rnd[31:0];
                    chk("z", z, cur.y);
                    $display("burst: z=%0d expected=%0d", $signed(z), $signed(cur.y));
                    pos = -1;
                end else begin
                    pos++;
                end
            end
            if (bus.in_push && bus.in_ready) pos = 0;
        end
    end

    task automatic model_accept(input int data);
        burst_t b;
        longint sum;
        int n;
        samples.push_back(data);
        n   = samples.size() - 1;
        sum = 0;
        b   = '0;
        for (int k = 0; k < N; k++) begin
            int s;
            s      = (n - k >= 0) ? samples[n-k] : 0;
            b.q[k] = s;
            b.h[k] = coef_m[k];
            sum    = sum + longint'(s) * longint'(coef_m[k]);
        end
        b.h[N] = shift_m;
        sum    = (sum + ((shift_m > 0) ? (longint'(1) << (shift_m - 1)) : 0)) >>> shift_m;
        b.y    = sum[31:0];
        exp_bq.push_back(b);
        accept_cyc.push_back(cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int ncyc);
        rst = 1'b1;
        bus.in_push = 1'b0;
        bus.cfg_we  = 1'b0;
        repeat (ncyc) @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < N; k++) coef_m[k] = 0;
        shift_m = 0;
        samples.delete();
        @(negedge clk);
        chk("rst_ready_after", bus.in_ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_pushin_after", bus.f_pushin, 0);
        chk("rst_cmd", bus.f_cmd, 0);
        chk("rst_q", bus.f_q, 0);
        chk("rst_h", bus.f_h, 0);
        chk("rst_cfg_err", bus.cfg_err, 0);
        tick();
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!bus.busy) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("idle_timeout", 0, 1);
        tick();
    endtask

    task automatic cfg_write(input logic [7:0] addr, input int data);
        wait_idle();
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = addr;
        bus.cfg_data = data;
        tick();
        bus.cfg_we = 1'b0;
        if (addr < N) coef_m[addr] = data;
        else if (addr == 8'hFF) shift_m = data & 127;
    endtask

    task automatic send_sample(input int data);
        bit ok;
        ok = 0;
        bus.in_data = data;
        bus.in_push = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                model_accept(data);
                ok = 1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 0, 1);
        tick();
        bus.in_push = 1'b0;
    endtask

    task automatic stream(input int cnt);
        int got;
        got = 0;
        bus.in_push = 1'b1;
        bus.in_data = rnd16();
        for (int i = 0; i < 400 && got < cnt; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                model_accept(int'(bus.in_data));
                got++;
                tick();
                bus.in_data = rnd16();
            end
        end
        if (got < cnt) chk("stream_timeout", got, cnt);
        bus.in_push = 1'b0;
    endtask

    initial begin
        int e0, a0;
        bus.in_push = 0; bus.in_data = 0;
        bus.cfg_we = 0; bus.cfg_addr = 0; bus.cfg_data = 0;
        do_reset(3);

        // impulse response
        for (int k = 0; k < N; k++) cfg_write(8'(k), k + 1);
        cfg_write(8'hFF, 0);
        send_sample(1);
        for (int i = 0; i < 9; i++) send_sample(0);

        // history wrap-around with a ramp
        do_reset(2);
        for (int k = 0; k < N; k++) cfg_write(8'(k), 1);
        for (int i = 1; i <= 12; i++) send_sample(i);

        // rounding
        do_reset(2);
        cfg_write(8'd0, 1);
        cfg_write(8'hFF, 1);
        send_sample(5);
        send_sample(4);
        cfg_write(8'hFF, 2);
        send_sample(-6);

        // config write while busy is dropped
        e0 = cfg_err_cnt;
        cfg_write(8'd0, 3);
        cfg_write(8'd1, 2);
        send_sample(7);
        tick(); tick();
        bus.cfg_we = 1'b1; bus.cfg_addr = 8'd0; bus.cfg_data = 99;
        tick();
        bus.cfg_we = 1'b0;
        wait_idle();
        chk("busy_cfg_err", cfg_err_cnt - e0, 1);
        send_sample(5);

        // config coinciding with a sample loses
        wait_idle();
        e0 = cfg_err_cnt;
        bus.in_data = 11; bus.in_push = 1'b1;
        bus.cfg_we = 1'b1; bus.cfg_addr = 8'd1; bus.cfg_data = 55;
        @(negedge clk);
        chk("coinc_ready", bus.in_ready, 1);
        if (bus.in_ready) model_accept(11);
        tick();
        bus.in_push = 1'b0; bus.cfg_we = 1'b0;
        wait_idle();
        chk("coinc_cfg_err", cfg_err_cnt - e0, 1);
        send_sample(-3);

        // reset in the middle of a burst
        send_sample(9);
        tick(); tick();
        do_reset(3);
        for (int k = 0; k < N; k++) cfg_write(8'(k), k - 3);
        send_sample(4);

        // back-to-back acceptance spacing
        wait_idle();
        a0 = accept_cyc.size();
        stream(4);
        for (int i = 1; i < 4; i++)
            chk("b2b_gap", accept_cyc[a0+i] - accept_cyc[a0+i-1], N + 3);

        // randomised traffic
        do_reset(1);
        for (int k = 0; k < N; k++) cfg_write(8'(k), rnd16());
        cfg_write(8'hFF, int'($urandom_range(12, 0)));
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(7, 0) == 0) cfg_write(8'hFF, int'($urandom_range(12, 0)));
            if ($urandom_range(3, 0) == 0) stream(2);
            else send_sample(rnd16());
            repeat ($urandom_range(2, 0)) tick();
        end

        wait_idle();
        repeat (3) tick();
        chk("pending_bursts", exp_bq.size(), 0);
        chk("burst_closed", pos < 0, 1);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
